multicycle_controller: RTL

- Multicycle control FSM driving the CPU data path's enables and mux selects.
- Consumes the instruction-register opcode and the registered zero flag from the data path.
- Sequences fetch, PC increment, execute and writeback for each 8-bit instruction (4-bit opcode plus 4-bit operand).

---
 rtl/multicycle_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Multicycle CPU control FSM: fetch, PC increment, execute, writeback.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int OPCODE_WIDTH = 4,
    parameter int ALU_OP_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    reg_write,
    output logic                    mem_write,
    output logic                    alu_write,
    output logic                    zero_write,
    output logic [1:0]              alu_sel1,
    output logic [1:0]              alu_sel2,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic [1:0]              result_sel,
    output logic                    halted
);

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_ST   = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_BZ   = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(15);

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = ALU_OP_WIDTH'(3);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_INCR     = 4'd1,
        S_EXEC_ALU = 4'd2,
        S_WB_ALU   = 4'd3,
        S_LD_RD    = 4'd4,
        S_LD_WB    = 4'd5,
        S_ST_WR    = 4'd6,
        S_BRANCH   = 4'd7,
        S_HALT     = 4'd8
    } state_t;

    state_t r_state;

    // Binary encoding: the seven unused codes fall into the default arm and recover to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    r_state <= S_INCR;
                S_INCR: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: r_state <= S_EXEC_ALU;
                        OP_LD:          r_state <= S_LD_RD;
                        OP_ST:          r_state <= S_ST_WR;
                        OP_JMP, OP_BZ:  r_state <= S_BRANCH;
                        OP_HALT:        r_state <= S_HALT;
                        default:        r_state <= S_FETCH;
                    endcase
                end
                S_EXEC_ALU: r_state <= S_WB_ALU;
                S_WB_ALU:   r_state <= S_FETCH;
                S_LD_RD:    r_state <= S_LD_WB;
                S_LD_WB:    r_state <= S_FETCH;
                S_ST_WR:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                S_HALT:     r_state <= S_HALT;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Decode is combinational so that reset suppresses every enable in the same cycle.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_write  = 1'b0;
        zero_write = 1'b0;
        alu_sel1   = 2'd0;
        alu_sel2   = 2'd0;
        alu_op     = ALU_ADD;
        result_sel = 2'd0;
        halted     = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: ir_write = 1'b1;
                S_INCR: begin
                    pc_write   = 1'b1;
                    alu_sel1   = 2'd2;
                    alu_sel2   = 2'd1;
                    result_sel = 2'd2;
                end
                S_EXEC_ALU: begin
                    alu_write  = 1'b1;
                    zero_write = 1'b1;
                    alu_sel2   = (opcode == OP_ADDI) ? 2'd0 : 2'd2;
                    case (opcode)
                        OP_SUB:  alu_op = ALU_SUB;
                        OP_AND:  alu_op = ALU_AND;
                        OP_OR:   alu_op = ALU_OR;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                S_WB_ALU: begin
                    reg_write  = 1'b1;
                    result_sel = 2'd1;
                end
                S_LD_WB:  reg_write = 1'b1;
                S_ST_WR:  mem_write = 1'b1;
                S_BRANCH: begin
                    pc_write   = (opcode == OP_JMP) ? 1'b1 : zero;
                    alu_sel1   = 2'd1;
                    alu_sel2   = 2'd3;
                    result_sel = 2'd2;
                end
                S_HALT:   halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
